// File: rtl/serial_subtractor_ctrl_if.sv
// Request/result bundle for serial_subtractor_ctrl.
//
// Handshake: the master drives start with operands x/y. A request is taken
// on a rising clk edge where start=1 and ready=1. x and y are sampled on
// that edge only and may change freely afterwards. A start seen while
// ready=0 is dropped, not queued. Each accepted request produces exactly one
// one-cycle done pulse. diff/b_out are valid from that pulse onwards and
// are held until the next completion.
//
// Signals:
//   start  master -> slave  request
//   x, y   master -> slave  minuend / subtrahend
//   ready  slave -> master  idle, request can be taken
//   busy   slave -> master  subtraction in progress
//   done   slave -> master  one-cycle completion pulse
//   diff   slave -> master  x - y mod 2^WIDTH
//   b_out  slave -> master  final borrow (x < y unsigned)
interface serial_subtractor_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;

  modport master (
    output start, x, y,
    input  ready, busy, done, diff, b_out
  );

  modport slave (
    input  start, x, y,
    output ready, busy, done, diff, b_out
  );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor with a start/done controller.
// A single full-subtractor cell (two half subtractors plus a borrow flop)
// is stepped over the operands LSB-first, one bit per clock.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   sub_if       slave side of serial_subtractor_ctrl_if
//                (start/x/y in, ready/busy/done/diff/b_out out)
//   state_dbg_o  current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Timing: start accepted at edge E0 -> busy for WIDTH cycles -> done in the
// cycle after edge E0+WIDTH -> back in IDLE, next start taken at E0+WIDTH+2.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_subtractor_ctrl_if.slave sub_if,
  output logic [1:0]              state_dbg_o
);

  // One extra bit so the counter never wraps, including WIDTH=32.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] xs_q, xs_d;
  logic [WIDTH-1:0] ys_q, ys_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;

  // Full-subtractor cell on the current LSBs.
  logic             bit_a;
  logic             bit_c;
  logic             bit_d;
  logic             borrow_nx;
  // Result register with the new bit prepended; the upper WIDTH bits are
  // the right-shifted result. Written this way so WIDTH=1 needs no
  // special-case slice.
  logic [WIDTH:0]   rs_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      xs_q     <= '0;
      ys_q     <= '0;
      rs_q     <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      b_out_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      rs_q     <= rs_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      b_out_q  <= b_out_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    xs_d      = xs_q;
    ys_d      = ys_q;
    rs_d      = rs_q;
    borrow_d  = borrow_q;
    cnt_d     = cnt_q;
    diff_d    = diff_q;
    b_out_d   = b_out_q;

    bit_a     = xs_q[0];
    bit_c     = ys_q[0];
    bit_d     = bit_a ^ bit_c ^ borrow_q;
    borrow_nx = (~bit_a & bit_c) | (~(bit_a ^ bit_c) & borrow_q);
    rs_shift  = {bit_d, rs_q};

    unique case (state_q)
      S_IDLE: begin
        if (sub_if.start) begin
          xs_d     = sub_if.x;
          ys_d     = sub_if.y;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        rs_d     = rs_shift[WIDTH:1];
        xs_d     = xs_q >> 1;
        ys_d     = ys_q >> 1;
        borrow_d = borrow_nx;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Publish the fully shifted result, including this edge's bit.
          diff_d  = rs_shift[WIDTH:1];
          b_out_d = borrow_nx;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status is decoded from the state register only.
  assign sub_if.ready = (state_q == S_IDLE);
  assign sub_if.busy  = (state_q == S_RUN);
  assign sub_if.done  = (state_q == S_DONE);
  assign sub_if.diff  = diff_q;
  assign sub_if.b_out = b_out_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Testbench for serial_subtractor_ctrl: three instances (WIDTH 8, 1, 16)
// share clock and reset. Inputs are driven and outputs sampled on the
// falling edge; the DUT acts on the rising edge.
module tb_serial_subtractor_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_ctrl_if #(.WIDTH(8))  if8 ();
  serial_subtractor_ctrl_if #(.WIDTH(1))  if1 ();
  serial_subtractor_ctrl_if #(.WIDTH(16)) if16 ();
  logic [1:0] st8, st1, st16;

  serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .sub_if(if8), .state_dbg_o(st8)
  );
  serial_subtractor_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .sub_if(if1), .state_dbg_o(st1)
  );
  serial_subtractor_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .sub_if(if16), .state_dbg_o(st16)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [16:0] exp_q[$];
  int          acc_q[$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  // One WIDTH=8 operation with full cycle-by-cycle timing checks.
  task automatic op8(input logic [7:0] xv, input logic [7:0] yv,
                     input bit chk_hold, input logic [7:0] hold_v);
    logic [8:0] exp;
    int t;
    exp = {1'b0, xv} - {1'b0, yv};
    t = 0;
    while (!if8.ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("op8_idle_wait", if8.ready, 1);
    if8.x = xv;
    if8.y = yv;
    if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    if8.x = 8'($urandom);
    if8.y = 8'($urandom);
    check("op8_ready_drop", if8.ready, 0);
    for (int k = 0; k < 8; k++) begin
      check("op8_busy", if8.busy, 1);
      check("op8_no_done", if8.done, 0);
      if (chk_hold) check("op8_diff_hold", if8.diff, hold_v);
      @(negedge clk);
      if8.x = 8'($urandom);
      if8.y = 8'($urandom);
    end
    check("op8_done", if8.done, 1);
    check("op8_busy_low", if8.busy, 0);
    check("op8_diff", if8.diff, exp[7:0]);
    check("op8_bout", if8.b_out, exp[8]);
    @(negedge clk);
    check("op8_done_pulse", if8.done, 0);
    check("op8_ready_back", if8.ready, 1);
    check("op8_diff_held", if8.diff, exp[7:0]);
  endtask

  task automatic op1(input logic xv, input logic yv);
    logic [1:0] exp;
    exp = {1'b0, xv} - {1'b0, yv};
    check("op1_idle", if1.ready, 1);
    if1.x = xv;
    if1.y = yv;
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    check("op1_busy", if1.busy, 1);
    check("op1_no_done", if1.done, 0);
    @(negedge clk);
    check("op1_done", if1.done, 1);
    check("op1_result", {if1.b_out, if1.diff}, {exp[1], exp[0]});
    @(negedge clk);
    check("op1_done_pulse", if1.done, 0);
    check("op1_ready", if1.ready, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: time %0t exceeded limit 2000000", $time);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int done_cyc[$];
    int seen;
    int ndone;
    int cyc;
    int t;
    logic [15:0] xv, yv;
    logic [16:0] e;
    int a;

    rst = 1'b1;
    if8.start = 1'b0;  if8.x = '0;  if8.y = '0;
    if1.start = 1'b0;  if1.x = '0;  if1.y = '0;
    if16.start = 1'b0; if16.x = '0; if16.y = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", if8.ready, 1);
    check("rst_busy", if8.busy, 0);
    check("rst_done", if8.done, 0);
    check("rst_diff", if8.diff, 0);
    check("rst_bout", if8.b_out, 0);
    check("rst_ready1", if1.ready, 1);
    check("rst_ready16", if16.ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Directed WIDTH=8 operations.
    op8(8'h35, 8'h12, 1'b0, 8'h00);
    op8(8'h12, 8'h35, 1'b0, 8'h00);
    op8(8'h00, 8'h01, 1'b1, 8'hDD);
    op8(8'hFF, 8'hFF, 1'b1, 8'hFF);

    // start held high: one operation per WIDTH+2 cycles, operand changes
    // while not ready must not leak into the result.
    if8.start = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (if8.done) begin
        done_cyc.push_back(c);
        check("held_diff", if8.diff, 8'h91);
        check("held_bout", if8.b_out, 0);
      end
      if (if8.ready) begin
        if8.x = 8'hA0;
        if8.y = 8'h0F;
      end else begin
        if8.x = 8'($urandom);
        if8.y = 8'($urandom);
      end
      @(negedge clk);
    end
    if8.start = 1'b0;
    check("held_pulses", done_cyc.size(), 3);
    for (int i = 1; i < done_cyc.size(); i++)
      check("held_period", done_cyc[i] - done_cyc[i-1], 10);
    t = 0;
    while (!if8.ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("held_drain", if8.ready, 1);

    // Asynchronous reset in the 4th RUN cycle.
    if8.x = 8'h77;
    if8.y = 8'h11;
    if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", if8.busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_ready", if8.ready, 1);
    check("abort_busy", if8.busy, 0);
    check("abort_done", if8.done, 0);
    check("abort_diff", if8.diff, 0);
    check("abort_bout", if8.b_out, 0);
    if8.start = 1'b1;  // reset must win over start
    @(negedge clk);
    check("rst_wins", if8.ready, 1);
    rst = 1'b0;
    if8.start = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (if8.done) seen++;
    end
    check("abort_no_done", seen, 0);
    op8(8'h05, 8'h03, 1'b0, 8'h00);

    // WIDTH=1 truth table.
    for (int i = 0; i < 4; i++) begin
      logic [1:0] p;
      p = 2'(i);
      op1(p[1], p[0]);
    end

    // Random WIDTH=16 stream with start held high.
    ndone = 0;
    cyc = 0;
    if16.start = 1'b1;
    while (ndone < 1000 && cyc < 30000) begin
      if (if16.done) begin
        if (exp_q.size() == 0) begin
          check("r16_unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("r16_result", {if16.b_out, if16.diff}, e);
          check("r16_latency", cyc - a, 17);
        end
        ndone++;
      end
      if (if16.ready) begin
        case ($urandom_range(0, 7))
          0: begin xv = 16'($urandom); yv = xv; end
          1: begin xv = 16'h0000; yv = 16'($urandom); end
          2: begin xv = 16'($urandom); yv = 16'hFFFF; end
          default: begin xv = 16'($urandom); yv = 16'($urandom); end
        endcase
        exp_q.push_back({1'b0, xv} - {1'b0, yv});
        acc_q.push_back(cyc);
      end else begin
        xv = 16'($urandom);
        yv = 16'($urandom);
      end
      if16.x = xv;
      if16.y = yv;
      @(negedge clk);
      cyc++;
    end
    if16.start = 1'b0;
    check("r16_count", ndone, 1000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
